// File: rtl/fc_share_arbiter.sv
// Round-robin owner of one fc engine: a granted requester loads N words, then drains M results.
// Grant takes 1 IDLE cycle; streams are routed combinationally with 0 latency and backpressure passes straight through.
module fc_share_arbiter #(
    parameter int NREQ = 4,
    parameter int M    = 6,
    parameter int N    = 8,
    parameter int T    = 16,
    localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*T-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [T-1:0]      resp_data,
    output logic              eng_input_valid,
    input  logic              eng_input_ready,
    output logic [T-1:0]      eng_input_data,
    input  logic              eng_output_valid,
    output logic              eng_output_ready,
    input  logic [T-1:0]      eng_output_data,
    output logic [GW-1:0]     grant_id,
    output logic              busy
);

    localparam int ICW = $clog2(N + 1);
    localparam int OCW = $clog2(M + 1);
    localparam logic [ICW-1:0] IN_LAST  = ICW'(N - 1);
    localparam logic [ICW-1:0] IN_TERM  = ICW'(N);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(M - 1);
    localparam logic [OCW-1:0] OUT_TERM = OCW'(M);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   prio_ptr_q;
    logic [GW-1:0]   prio_ptr_d;
    logic [ICW-1:0]  in_cnt_q;
    logic [ICW-1:0]  in_cnt_d;
    logic [OCW-1:0]  out_cnt_q;
    logic [OCW-1:0]  out_cnt_d;
    logic            busy_q;
    logic [GW-1:0]   cand;
    logic [GW-1:0]   pick_idx;
    logic            pick_vld;
    logic [T-1:0]    sel_dat;
    logic            in_fire;
    logic            out_fire;

    // Scan downwards so the candidate closest to prio_ptr is the last (winning) write.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = GW'((int'(prio_ptr_q) + k) % NREQ);
            if (req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (GW'(i) == grant_q) begin
                sel_dat = req_data[i*T +: T];
            end
        end
    end

    always_comb begin
        req_ready        = '0;
        resp_valid       = '0;
        eng_input_valid  = 1'b0;
        eng_input_data   = '0;
        eng_output_ready = 1'b0;
        if (state_q == LOAD) begin
            eng_input_valid    = req_valid[grant_q];
            eng_input_data     = sel_dat;
            req_ready[grant_q] = eng_input_ready;
        end
        if (state_q == DRAIN) begin
            resp_valid[grant_q] = eng_output_valid;
            eng_output_ready    = resp_ready[grant_q];
        end
    end

    assign in_fire    = (state_q == LOAD) && req_valid[grant_q] && eng_input_ready;
    assign out_fire   = (state_q == DRAIN) && eng_output_valid && resp_ready[grant_q];
    assign in_cnt_d   = (in_cnt_q == IN_TERM) ? in_cnt_q : in_cnt_q + ICW'(1);
    assign out_cnt_d  = (out_cnt_q == OUT_TERM) ? out_cnt_q : out_cnt_q + OCW'(1);
    assign prio_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);

    assign resp_data = eng_output_data;
    assign grant_id  = grant_q;
    assign busy      = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            prio_ptr_q <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q   <= pick_idx;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        in_cnt_q <= in_cnt_d;
                        if (in_cnt_q == IN_LAST) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        out_cnt_q <= out_cnt_d;
                        if (out_cnt_q == OUT_LAST) begin
                            prio_ptr_q <= prio_ptr_d;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_share_arbiter.sv
// Directed bench for fc_share_arbiter: job-level reference model checked every cycle, plus literal job expectations.
module tb_fc_share_arbiter;
    localparam int NREQ = 4;
    localparam int M    = 6;
    localparam int N    = 8;
    localparam int T    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready = '0;
    logic [15:0] resp_data;
    logic        eng_input_valid;
    logic        eng_input_ready = 1'b0;
    logic [15:0] eng_input_data;
    logic        eng_output_valid = 1'b0;
    logic        eng_output_ready;
    logic [15:0] eng_output_data = '0;
    logic [1:0]  grant_id;
    logic        busy;

    fc_share_arbiter #(.NREQ(NREQ), .M(M), .N(N), .T(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .eng_input_valid(eng_input_valid), .eng_input_ready(eng_input_ready),
        .eng_input_data(eng_input_data),
        .eng_output_valid(eng_output_valid), .eng_output_ready(eng_output_ready),
        .eng_output_data(eng_output_data),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 collecting N words, 2 returning M results.
    int m_phase = 0, m_owner = 0, m_in = 0, m_out = 0, m_ptr = 0;

    int words_left[4], seq[4], in_fires[4], resp_fires[4];
    int out_word = 0, cyc = 0, run_cyc = 0, leak1 = 0;
    bit in_bp = 1'b0, rr_bp = 1'b0, prev_busy = 1'b0;
    int grants[$];
    int grant_cyc[$];
    logic [15:0] in_data[$];
    logic [15:0] out_data[$];

    function automatic logic bit_of(input logic [3:0] v, input int i);
        return v[i[1:0]];
    endfunction

    function automatic logic [15:0] word_of(input logic [63:0] v, input int i);
        return 16'(v >> (16 * i));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_in = 0; m_out = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        int w;
        if (!reset) begin
            model_reset();
        end else if (m_phase == 0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && bit_of(req_valid, (m_ptr + k) % NREQ)) w = (m_ptr + k) % NREQ;
            if (w >= 0) begin
                m_owner = w; m_in = 0; m_out = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (bit_of(req_valid, m_owner) && eng_input_ready) begin
                m_in++;
                if (m_in == N) m_phase = 2;
            end
        end else begin
            if (eng_output_valid && bit_of(resp_ready, m_owner)) begin
                m_out++;
                if (m_out == M) begin
                    m_ptr = (m_owner + 1) % NREQ;
                    m_phase = 0;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        logic [3:0]  e_rr, e_rv;
        logic [15:0] e_eid;
        e_rr  = (m_phase == 1 && eng_input_ready) ? 4'(1 << m_owner) : 4'd0;
        e_rv  = (m_phase == 2 && eng_output_valid) ? 4'(1 << m_owner) : 4'd0;
        e_eid = (m_phase == 1) ? word_of(req_data, m_owner) : 16'd0;
        chk("req_ready", req_ready, e_rr);
        chk("resp_valid", resp_valid, e_rv);
        chk("eng_input_valid", eng_input_valid, m_phase == 1 && bit_of(req_valid, m_owner));
        chk("eng_input_data", eng_input_data, e_eid);
        chk("eng_output_ready", eng_output_ready, m_phase == 2 && bit_of(resp_ready, m_owner));
        chk("resp_data", resp_data, eng_output_data);
        chk("grant_id", grant_id, m_owner);
        chk("busy", busy, m_phase != 0);
    endtask

    task automatic drive();
        logic [3:0]  v;
        logic [63:0] d;
        v = '0; d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (words_left[i] > 0) v |= 4'(1 << i);
            d |= 64'((i << 8) | (seq[i] + 1)) << (16 * i);
        end
        req_valid        = v;
        req_data         = d;
        eng_input_ready  = in_bp ? (cyc % 3 != 0) : 1'b1;
        eng_output_valid = (cyc % 5 != 4);
        eng_output_data  = 16'(out_word);
        resp_ready       = (rr_bp && (cyc % 2 == 1)) ? 4'h0 : 4'hF;
    endtask

    task automatic cycle();
        logic [3:0] fi, fr;
        logic eof;
        @(negedge clk);
        compare_outputs();
        fi  = req_valid & req_ready;
        fr  = resp_valid & resp_ready;
        eof = eng_output_valid & eng_output_ready;
        if (eng_input_valid && eng_input_ready) in_data.push_back(eng_input_data);
        if (fr != 4'd0) out_data.push_back(resp_data);
        if (busy && !prev_busy) begin
            grants.push_back(int'(grant_id));
            grant_cyc.push_back(run_cyc);
        end
        if (busy && grant_id == 2'd0 && (req_ready[1] || resp_valid[1])) leak1++;
        prev_busy = busy;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (bit_of(fi, i)) begin words_left[i]--; seq[i]++; in_fires[i]++; end
            if (bit_of(fr, i)) resp_fires[i]++;
        end
        if (eof) out_word++;
        cyc++;
        run_cyc++;
        drive();
    endtask

    task automatic clear_logs();
        grants.delete(); grant_cyc.delete(); in_data.delete(); out_data.delete();
        for (int i = 0; i < NREQ; i++) begin
            in_fires[i] = 0; resp_fires[i] = 0;
        end
        leak1 = 0;
    endtask

    task automatic run(input int maxc);
        bit done;
        bit idle_words;
        done = 1'b0;
        run_cyc = 0;
        drive();
        for (int c = 0; c < maxc && !done; c++) begin
            cycle();
            idle_words = 1'b1;
            for (int i = 0; i < NREQ; i++) if (words_left[i] != 0) idle_words = 1'b0;
            if (idle_words && !prev_busy) done = 1'b1;
        end
        if (!done) begin
            n_checks++; n_err++;
            $display("FAIL timeout: jobs not finished within %0d cycles", maxc);
        end
    endtask

    task automatic check_grants(input string nm, input int exp[$]);
        chk({nm, "_count"}, grants.size(), exp.size());
        for (int k = 0; k < exp.size() && k < grants.size(); k++) chk(nm, grants[k], exp[k]);
    endtask

    task automatic check_results(input string nm, input int base);
        chk({nm, "_count"}, out_data.size(), M);
        for (int k = 0; k < out_data.size(); k++) chk(nm, out_data[k], 16'(base + k));
    endtask

    initial begin
        int base;
        for (int i = 0; i < NREQ; i++) begin words_left[i] = 0; seq[i] = 0; end
        clear_logs();
        drive();
        repeat (3) cycle();
        chk("reset_grant", grant_id, 0);
        chk("reset_busy", busy, 0);
        chk("reset_req_ready", req_ready, 0);
        reset = 1'b1;
        cycle();

        // 1) single job from requester 0
        clear_logs(); base = out_word; words_left[0] = 8;
        run(200);
        check_grants("t1_grant", '{0});
        if (grant_cyc.size() > 0) chk("t1_grant_latency", grant_cyc[0], 1);
        chk("t1_in_count", in_data.size(), 8);
        for (int k = 0; k < in_data.size(); k++) chk("t1_in_word", in_data[k], 16'(k + 1));
        check_results("t1_result", base);
        chk("t1_resp_other", resp_fires[1] + resp_fires[2] + resp_fires[3], 0);

        // 2) fairness from a fresh pointer
        reset = 1'b0; model_reset(); cycle(); reset = 1'b1; cycle();
        clear_logs(); words_left[0] = 16; words_left[2] = 16;
        run(400);
        check_grants("t2_order", '{0, 2, 0, 2});
        chk("t2_resp0", resp_fires[0], 12);
        chk("t2_resp2", resp_fires[2], 12);

        // 3) pointer wrap: pointer at 3 must favour 3 over 1
        clear_logs(); words_left[3] = 8; words_left[1] = 8;
        run(400);
        check_grants("t3_order", '{3, 1});

        // 4) input and result backpressure on requester 2
        clear_logs(); base = out_word; words_left[2] = 8; in_bp = 1'b1; rr_bp = 1'b1;
        run(400);
        in_bp = 1'b0; rr_bp = 1'b0;
        check_grants("t4_grant", '{2});
        chk("t4_in_count", in_fires[2], 8);
        check_results("t4_result", base);

        // 5) requester 1 waits untouched while 0 owns the engine
        clear_logs(); words_left[0] = 8; words_left[1] = 8;
        run(400);
        check_grants("t5_order", '{0, 1});
        chk("t5_leak1", leak1, 0);

        // 6) asynchronous reset after 3 accepted words
        clear_logs(); words_left[2] = 8; run_cyc = 0; drive();
        for (int c = 0; c < 50 && in_fires[2] < 3; c++) cycle();
        chk("t6_pre_in", in_fires[2], 3);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_grant", grant_id, 0);
        chk("t6_rst_req_ready", req_ready, 0);
        chk("t6_rst_in_valid", eng_input_valid, 0);
        chk("t6_rst_in_data", eng_input_data, 0);
        words_left[2] = 0;
        drive();
        repeat (2) cycle();
        reset = 1'b1;
        clear_logs(); words_left[1] = 8; words_left[3] = 8;
        run(400);
        check_grants("t6_order", '{1, 3});
        chk("t6_in1", in_fires[1], 8);
        chk("t6_resp1", resp_fires[1], 6);
        chk("t6_resp3", resp_fires[3], 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
